mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; widths SHALL come from lc3b_types (lc3b_word = 16 bits, lc3b_line = 128 bits).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 icache_pmem_read  input  1  I-cache line-read request.
REQ-005 icache_pmem_write  input  1  I-cache line-write request.
REQ-006 icache_pmem_address  input  lc3b_word  I-cache line address.
REQ-007 icache_pmem_wdata  input  lc3b_line  I-cache write line.
REQ-008 icache_pmem_rdata  output  lc3b_line  read line returned to the I-cache.
REQ-009 icache_pmem_resp  output  1  I-cache transaction-complete pulse.
REQ-010 dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata, dcache_pmem_rdata, dcache_pmem_resp  SHALL have the same directions, widths and meanings as REQ-004..009, for the D-cache.
REQ-011 pmem_read, pmem_write  output  1  request strobes to physical memory.
REQ-012 pmem_address  output  lc3b_word; pmem_wdata  output  lc3b_line  latched request data to physical memory.
REQ-013 pmem_rdata  input  lc3b_line; pmem_resp  input  1  memory read data and completion.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT_I, GRANT_D.
REQ-015 A requester is pending when its read or write input is 1.
REQ-016 In IDLE with only one requester pending, the next state SHALL be that requester's grant state.
REQ-017 In IDLE with both pending, the grant SHALL go to the requester not recorded in last_grant; last_grant SHALL update to the winner.
REQ-018 On the IDLE->GRANT transition, the winner's address, wdata and op SHALL be latched; op = write if its write input is 1, else read (write wins if both are set).
REQ-019 In a GRANT state, pmem_read/pmem_write SHALL reflect the latched op; pmem_address/pmem_wdata SHALL be the latched values; requester inputs SHALL be ignored until completion.
REQ-020 In IDLE, pmem_read and pmem_write SHALL be 0.
REQ-021 pmem_rdata SHALL be broadcast combinationally to both icache_pmem_rdata and dcache_pmem_rdata.
REQ-022 In GRANT_x with pmem_resp = 1, the arbiter SHALL assert x_pmem_resp combinationally in the same cycle, and the next state SHALL be IDLE.
REQ-023 The non-granted requester's resp SHALL always be 0; pmem_resp in IDLE SHALL be ignored.
REQ-024 Latency: a request first seen in IDLE at cycle N SHALL drive pmem_read/pmem_write from cycle N+1.
REQ-025 Latency: after a completion at cycle M, a still-pending requester SHALL be granted at the M+1 -> M+2 edge, with pmem strobes from cycle M+2.
REQ-026 Requesters SHALL hold their request until resp; a request still asserted in the cycle after its own resp SHALL be treated as a new request.
REQ-027 There SHALL be no transaction timeout; a grant is held until pmem_resp.

Reset
REQ-028 While reset = 1 at a clock edge: state SHALL become IDLE, last_grant SHALL become I, and the latched address, wdata and op SHALL become 0.
REQ-029 Outputs while in IDLE after reset: pmem_read, pmem_write, icache_pmem_resp and dcache_pmem_resp SHALL be 0; pmem_address and pmem_wdata SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction, with strobes at 0 from the following cycle; a late pmem_resp SHALL produce no requester resp.

Verification
REQ-031 Single I-read: icache_pmem_read = 1 at address 0x1230 with pmem_resp after 3 cycles -> pmem_read = 1 and pmem_address = 0x1230 from N+1; icache_pmem_resp is a 1-cycle pulse; dcache_pmem_resp stays 0.
REQ-032 Simultaneous requests after reset: I-read at 0x0040 and D-write at 0x8000 -> D is served first (pmem_write = 1, address 0x8000); then I is served (pmem_read = 1, address 0x0040) starting 2 cycles after D's resp.
REQ-033 Repeated simultaneous requests: both requesters held continuously -> grants alternate D, I, D, I; no requester is granted twice in a row.
REQ-034 Input change during a grant: D-write granted, then dcache_pmem_address is changed to 0xFFFF mid-transaction -> pmem_address keeps the latched value until resp.
REQ-035 Reset mid-transaction: reset asserted during GRANT_I -> strobes are 0 from the next cycle; a subsequent pmem_resp yields no resp on either side; the next simultaneous request goes to D.
REQ-036 Read+write from the same requester: dcache_pmem_read = dcache_pmem_write = 1 -> pmem_write = 1 and pmem_read = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (I-cache / D-cache) arbiter in front of one physical memory port
//
// Purpose:
//   Grants the single physical-memory port to either the I-cache or the
//   D-cache, one whole line transaction at a time. The winner's address,
//   write line and operation are captured when the grant is taken, and
//   they are held until memory signals completion. When both caches are
//   waiting, the grant alternates between them.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   icache_pmem_read/write      I-cache request strobes (held until resp)
//   icache_pmem_address/wdata   I-cache request address / write line
//   icache_pmem_rdata/resp      read line and completion pulse to the I-cache
//   dcache_pmem_*               same set for the D-cache
//   pmem_read/write             strobes to physical memory
//   pmem_address/wdata          latched request to physical memory
//   pmem_rdata/resp             read line and completion from physical memory

package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
endpackage

module mem_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,

  input  logic     icache_pmem_read,
  input  logic     icache_pmem_write,
  input  lc3b_word icache_pmem_address,
  input  lc3b_line icache_pmem_wdata,
  output lc3b_line icache_pmem_rdata,
  output logic     icache_pmem_resp,

  input  logic     dcache_pmem_read,
  input  logic     dcache_pmem_write,
  input  lc3b_word dcache_pmem_address,
  input  lc3b_line dcache_pmem_wdata,
  output lc3b_line dcache_pmem_rdata,
  output logic     dcache_pmem_resp,

  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  // Which side won the most recent contested grant.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t   state;
  state_t   next_state;
  logic     last_grant;
  logic     next_last_grant;

  lc3b_word lat_address;
  lc3b_line lat_wdata;
  logic     lat_write;

  logic     i_pending;
  logic     d_pending;

  assign i_pending = icache_pmem_read | icache_pmem_write;
  assign d_pending = dcache_pmem_read | dcache_pmem_write;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LAST_I;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // Next-state logic. Requester inputs only matter in IDLE; a grant is held
  // for as long as memory takes, with no timeout.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (i_pending && d_pending) begin
          // Contested: the side that did not win last time goes now.
          if (last_grant == LAST_I) begin
            next_state      = GRANT_D;
            next_last_grant = LAST_D;
          end else begin
            next_state      = GRANT_I;
            next_last_grant = LAST_I;
          end
        end else if (i_pending) begin
          next_state = GRANT_I;
        end else if (d_pending) begin
          next_state = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture on the IDLE->GRANT edge. Write takes precedence when a
  // cache raises both strobes at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_address <= '0;
      lat_wdata   <= '0;
      lat_write   <= 1'b0;
    end else if (state == IDLE && next_state == GRANT_I) begin
      lat_address <= icache_pmem_address;
      lat_wdata   <= icache_pmem_wdata;
      lat_write   <= icache_pmem_write;
    end else if (state == IDLE && next_state == GRANT_D) begin
      lat_address <= dcache_pmem_address;
      lat_wdata   <= dcache_pmem_wdata;
      lat_write   <= dcache_pmem_write;
    end
  end

  // Output logic. Completion is passed straight through to the granted side
  // in the same cycle; memory responses seen in IDLE go nowhere.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state)
      GRANT_I: begin
        pmem_read        = ~lat_write;
        pmem_write       = lat_write;
        icache_pmem_resp = pmem_resp;
      end
      GRANT_D: begin
        pmem_read        = ~lat_write;
        pmem_write       = lat_write;
        dcache_pmem_resp = pmem_resp;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign pmem_address      = lat_address;
  assign pmem_wdata        = lat_wdata;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter

module tb_mem_arbiter;

  logic         clk;
  logic         reset;
  logic [1:0]   req_rd;
  logic [1:0]   req_wr;
  logic [15:0]  req_addr [2];
  logic [127:0] req_wd   [2];
  logic [127:0] icache_pmem_rdata;
  logic [127:0] dcache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_read    (req_rd[0]),
    .icache_pmem_write   (req_wr[0]),
    .icache_pmem_address (req_addr[0]),
    .icache_pmem_wdata   (req_wd[0]),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (req_rd[1]),
    .dcache_pmem_write   (req_wr[1]),
    .dcache_pmem_address (req_addr[1]),
    .dcache_pmem_wdata   (req_wd[1]),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Transaction-level reference: who owns memory (0 none, 1 I, 2 D), which
  // side won the last contested grant, and the captured transaction.
  int           m_owner;
  int           m_last;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  logic         m_wr;
  int           m_cnt;
  bit           done [2];

  initial begin
    logic [127:0] l1;
    logic [127:0] w2;
    logic [127:0] w4;
    bit           exp_d;

    reset = 1'b1;
    req_rd = '0;
    req_wr = '0;
    req_addr[0] = '0; req_addr[1] = '0;
    req_wd[0] = '0;   req_wd[1] = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    l1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    w2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    w4 = 128'h0f0f_0f0f_a5a5_a5a5_5a5a_5a5a_f0f0_f0f0;

    // Reset state.
    tick(); tick(); sample();
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    chk("rst_pmem_wdata", pmem_wdata, 128'(0));
    chk("rst_icache_resp", 128'(icache_pmem_resp), 128'(0));
    chk("rst_dcache_resp", 128'(dcache_pmem_resp), 128'(0));

    // Single I-read, memory answers in the third grant cycle.
    tick(); reset = 1'b0; req_rd[0] = 1'b1; req_addr[0] = 16'h1230; sample();
    chk("t1_idle_read", 128'(pmem_read), 128'(0));
    tick(); sample();
    chk("t1_read", 128'(pmem_read), 128'(1));
    chk("t1_write", 128'(pmem_write), 128'(0));
    chk("t1_address", 128'(pmem_address), 128'(16'h1230));
    chk("t1_iresp_early", 128'(icache_pmem_resp), 128'(0));
    tick(); sample();
    chk("t1_read_hold", 128'(pmem_read), 128'(1));
    tick(); pmem_resp = 1'b1; pmem_rdata = l1; sample();
    chk("t1_iresp", 128'(icache_pmem_resp), 128'(1));
    chk("t1_dresp", 128'(dcache_pmem_resp), 128'(0));
    chk("t1_irdata", icache_pmem_rdata, l1);
    chk("t1_drdata", dcache_pmem_rdata, l1);
    tick(); pmem_resp = 1'b0; req_rd[0] = 1'b0; sample();
    chk("t1_iresp_pulse", 128'(icache_pmem_resp), 128'(0));
    chk("t1_read_done", 128'(pmem_read), 128'(0));

    // Simultaneous after reset: D first, I two cycles after D's resp.
    reset = 1'b1; tick();
    reset = 1'b0;
    req_rd[0] = 1'b1; req_addr[0] = 16'h0040;
    req_wr[1] = 1'b1; req_addr[1] = 16'h8000; req_wd[1] = w2;
    sample();
    chk("t2_idle_write", 128'(pmem_write), 128'(0));
    tick(); sample();
    chk("t2_d_write", 128'(pmem_write), 128'(1));
    chk("t2_d_read", 128'(pmem_read), 128'(0));
    chk("t2_d_address", 128'(pmem_address), 128'(16'h8000));
    chk("t2_d_wdata", pmem_wdata, w2);
    tick(); pmem_resp = 1'b1; sample();
    chk("t2_dresp", 128'(dcache_pmem_resp), 128'(1));
    chk("t2_iresp_quiet", 128'(icache_pmem_resp), 128'(0));
    tick(); pmem_resp = 1'b0; req_wr[1] = 1'b0; sample();
    chk("t2_gap_strobes", 128'({pmem_read, pmem_write}), 128'(0));
    tick(); sample();
    chk("t2_i_read", 128'(pmem_read), 128'(1));
    chk("t2_i_address", 128'(pmem_address), 128'(16'h0040));
    tick(); pmem_resp = 1'b1; sample();
    chk("t2_iresp", 128'(icache_pmem_resp), 128'(1));
    chk("t2_dresp_quiet", 128'(dcache_pmem_resp), 128'(0));
    tick(); pmem_resp = 1'b0; req_rd[0] = 1'b0; sample();
    chk("t2_done", 128'(pmem_read), 128'(0));

    // Both held continuously from reset: D, I, D, I, D, I.
    reset = 1'b1; tick();
    reset = 1'b0;
    req_rd[0] = 1'b1; req_addr[0] = 16'h1111;
    req_wr[1] = 1'b1; req_addr[1] = 16'h2222;
    sample();
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0);
      tick(); pmem_resp = 1'b1; sample();
      chk("t3_address", 128'(pmem_address), exp_d ? 128'(16'h2222) : 128'(16'h1111));
      chk("t3_write", 128'(pmem_write), 128'(exp_d));
      chk("t3_dresp", 128'(dcache_pmem_resp), 128'(exp_d));
      chk("t3_iresp", 128'(icache_pmem_resp), 128'(!exp_d));
      tick(); pmem_resp = 1'b0;
      if (k == 5) begin
        req_rd[0] = 1'b0;
        req_wr[1] = 1'b0;
      end
      sample();
      chk("t3_idle_strobes", 128'({pmem_read, pmem_write}), 128'(0));
    end

    // D-cache inputs change mid-grant; the latched request must hold.
    req_wr[1] = 1'b1; req_addr[1] = 16'h3000; req_wd[1] = w4;
    tick(); sample();
    chk("t4_address", 128'(pmem_address), 128'(16'h3000));
    chk("t4_write", 128'(pmem_write), 128'(1));
    tick(); req_addr[1] = 16'hFFFF; req_wd[1] = ~w4; sample();
    chk("t4_address_hold", 128'(pmem_address), 128'(16'h3000));
    chk("t4_wdata_hold", pmem_wdata, w4);
    tick(); pmem_resp = 1'b1; sample();
    chk("t4_address_resp", 128'(pmem_address), 128'(16'h3000));
    chk("t4_dresp", 128'(dcache_pmem_resp), 128'(1));
    tick(); pmem_resp = 1'b0; req_wr[1] = 1'b0; sample();
    chk("t4_done", 128'({pmem_read, pmem_write}), 128'(0));

    // Reset during GRANT_I abandons it; late resp is dropped.
    req_rd[0] = 1'b1; req_addr[0] = 16'h5555;
    tick(); sample();
    chk("t5_granted", 128'(pmem_read), 128'(1));
    reset = 1'b1;
    tick(); reset = 1'b0; req_rd[0] = 1'b0; pmem_resp = 1'b1; sample();
    chk("t5_strobes", 128'({pmem_read, pmem_write}), 128'(0));
    chk("t5_iresp", 128'(icache_pmem_resp), 128'(0));
    chk("t5_dresp", 128'(dcache_pmem_resp), 128'(0));
    tick(); pmem_resp = 1'b0;
    req_rd[0] = 1'b1; req_addr[0] = 16'h6666;
    req_wr[1] = 1'b1; req_addr[1] = 16'h7777;
    sample();
    tick(); pmem_resp = 1'b1; sample();
    chk("t5_d_first", 128'(pmem_address), 128'(16'h7777));
    chk("t5_d_write", 128'(pmem_write), 128'(1));
    chk("t5_d_resp", 128'(dcache_pmem_resp), 128'(1));
    tick(); pmem_resp = 1'b0; req_rd[0] = 1'b0; req_wr[1] = 1'b0; sample();

    // Read and write together from D: write wins.
    req_rd[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 16'h4444;
    tick(); sample();
    chk("t6_write", 128'(pmem_write), 128'(1));
    chk("t6_read", 128'(pmem_read), 128'(0));
    chk("t6_address", 128'(pmem_address), 128'(16'h4444));
    tick(); pmem_resp = 1'b1; sample();
    chk("t6_dresp", 128'(dcache_pmem_resp), 128'(1));
    tick(); pmem_resp = 1'b0; req_rd[1] = 1'b0; req_wr[1] = 1'b0; sample();

    // Randomized traffic against the reference model.
    reset = 1'b1; tick(); reset = 1'b0;
    m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_wr = 1'b0; m_cnt = 0;
    done[0] = 1'b0; done[1] = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < 2; r++) begin
        bit newreq;
        newreq = 1'b0;
        if (m_owner == r + 1) begin
          if ($urandom_range(0, 3) == 0) begin
            req_addr[r] = 16'($urandom());
            req_wd[r] = rand128();
          end
        end else if (done[r]) begin
          if ($urandom_range(0, 1) == 0) newreq = 1'b1;
          else begin
            req_rd[r] = 1'b0;
            req_wr[r] = 1'b0;
          end
        end else if (!(req_rd[r] || req_wr[r])) begin
          newreq = ($urandom_range(0, 2) == 0);
        end
        if (newreq) begin
          int op;
          op = $urandom_range(0, 2);
          req_rd[r] = (op != 1);
          req_wr[r] = (op != 0);
          req_addr[r] = 16'($urandom());
          req_wd[r] = rand128();
        end
      end
      pmem_rdata = rand128();
      if (m_owner != 0) begin
        if (m_cnt == 0) pmem_resp = 1'b1;
        else begin
          pmem_resp = 1'b0;
          m_cnt--;
        end
      end else begin
        pmem_resp = ($urandom_range(0, 7) == 0);
      end

      sample();
      chk("rnd_pmem_read", 128'(pmem_read), 128'(m_owner != 0 && !m_wr));
      chk("rnd_pmem_write", 128'(pmem_write), 128'(m_owner != 0 && m_wr));
      chk("rnd_pmem_address", 128'(pmem_address), 128'(m_addr));
      chk("rnd_pmem_wdata", pmem_wdata, m_wdata);
      chk("rnd_icache_resp", 128'(icache_pmem_resp), 128'(m_owner == 1 && pmem_resp));
      chk("rnd_dcache_resp", 128'(dcache_pmem_resp), 128'(m_owner == 2 && pmem_resp));
      chk("rnd_icache_rdata", icache_pmem_rdata, pmem_rdata);
      chk("rnd_dcache_rdata", dcache_pmem_rdata, pmem_rdata);

      done[0] = 1'b0;
      done[1] = 1'b0;
      if (reset) begin
        m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
      end else if (m_owner != 0) begin
        if (pmem_resp) begin
          done[m_owner - 1] = 1'b1;
          m_owner = 0;
        end
      end else begin
        bit pi, pd;
        int w;
        pi = req_rd[0] || req_wr[0];
        pd = req_rd[1] || req_wr[1];
        w = 0;
        if (pi && pd) begin
          w = (m_last == 1) ? 2 : 1;
          m_last = w;
        end else if (pi) w = 1;
        else if (pd) w = 2;
        if (w != 0) begin
          m_owner = w;
          m_addr = req_addr[w - 1];
          m_wdata = req_wd[w - 1];
          m_wr = req_wr[w - 1];
          m_cnt = $urandom_range(0, 3);
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
